ram_master: RTL and testbench

Sequencing initiator for the single-port synchronous RAM: it turns CPU-side requests (valid/ready) into correctly timed EN/WE/RE/addr/DI cycles and returns read data through a valid/ready response channel. It supports single-word writes and auto-incrementing burst reads of 1..2^LenSize words. It sits between the CPU core (or loader) and the RAM, and is the only driver of the RAM port.

---
 rtl/ram_master.sv | 199 +++++++++++++++++++
 tb/tb_ram_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_master
// Purpose  : Sequencing initiator for a single-port synchronous RAM. Turns
//            CPU-side valid/ready requests into timed EN/WE/RE/addr/DI cycles
//            (single-word writes, auto-incrementing burst reads of
//            1..2^LenSize words) and returns read words through a
//            valid/ready response channel. Sole driver of the RAM port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_write                1 = single write, 0 = burst read
//   req_addr, req_len        start address, burst length minus one
//   req_wdata                write data
//   rsp_valid / rsp_ready    read response handshake
//   rsp_data, rsp_last       read word, final-word flag
//   busy                     high in any state other than idle
//   mem_addr, mem_di         RAM address / data-in
//   mem_en, mem_we, mem_re   RAM enable / write enable / read enable
//   mem_do                   RAM registered data-out
// ============================================================================
module ram_master #(
  parameter int AddrSize = 11,
  parameter int WordSize = 9,
  parameter int LenSize  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [AddrSize-1:0] req_addr,
  input  logic [LenSize-1:0]  req_len,
  input  logic [WordSize-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WordSize-1:0] rsp_data,
  output logic                rsp_last,
  output logic                busy,
  output logic [AddrSize-1:0] mem_addr,
  output logic [WordSize-1:0] mem_di,
  output logic                mem_en,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [WordSize-1:0] mem_do
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_HOLD  = 3'd4
  } state_t;

  localparam logic [AddrSize-1:0] c_addr_one = {{(AddrSize-1){1'b0}}, 1'b1};
  localparam logic [LenSize-1:0]  c_cnt_one  = {{(LenSize-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [LenSize-1:0]    r_cnt;
  logic [AddrSize-1:0]   r_mem_addr;
  logic [WordSize-1:0]   r_mem_di;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic                  r_mem_re;
  logic                  r_rsp_valid;
  logic                  r_rsp_last;
  logic [WordSize-1:0]   r_rsp_data;
  logic                  r_req_ready;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [LenSize-1:0]    w_cnt_nxt;
  logic [AddrSize-1:0]   w_mem_addr_nxt;
  logic [WordSize-1:0]   w_mem_di_nxt;
  logic                  w_mem_en_nxt;
  logic                  w_mem_we_nxt;
  logic                  w_mem_re_nxt;
  logic                  w_rsp_valid_nxt;
  logic                  w_rsp_last_nxt;
  logic [WordSize-1:0]   w_rsp_data_nxt;
  logic                  w_req_ready_nxt;
  logic                  w_busy_nxt;

  // Every output is a flop whose next value is decoded from the next state,
  // so outputs line up with the state they describe and never depend
  // combinationally on inputs. mem_addr doubles as the burst address pointer.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_di_nxt    = r_mem_di;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_re_nxt    = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_last_nxt  = r_rsp_last;
    w_rsp_data_nxt  = r_rsp_data;

    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_mem_addr_nxt = req_addr;
          w_cnt_nxt      = req_len;
          w_mem_en_nxt   = 1'b1;
          if (req_write) begin
            w_mem_di_nxt = req_wdata;
            w_mem_we_nxt = 1'b1;
            w_state_nxt  = ST_WR;
          end else begin
            w_mem_re_nxt = 1'b1;
            w_state_nxt  = ST_RD_ISSUE;
          end
        end
      end
      ST_WR: begin
        w_state_nxt = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // RAM DO was registered at the end of the issue cycle.
        w_rsp_data_nxt  = mem_do;
        w_rsp_last_nxt  = (r_cnt == '0);
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_last_nxt  = 1'b0;
          if (r_rsp_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_mem_addr_nxt = r_mem_addr + c_addr_one;  // wraps modulo 2^AddrSize
            w_cnt_nxt      = r_cnt - c_cnt_one;
            w_mem_en_nxt   = 1'b1;
            w_mem_re_nxt   = 1'b1;
            w_state_nxt    = ST_RD_ISSUE;
          end
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_last_nxt  = 1'b0;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_di    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
      r_req_ready <= 1'b0;  // held low during reset, rises on first edge after
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_di    <= w_mem_di_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_last  <= w_rsp_last_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_di    = r_mem_di;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;

endmodule
`default_nettype wire

// File: tb/tb_ram_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_master
// Purpose  : Directed self-checking bench for ram_master with a behavioural
//            single-port synchronous RAM (registered DO) attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_master;

  localparam int AW = 11;
  localparam int DW = 9;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic          mem_en;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_do;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ram   [0:(1<<AW)-1];
  logic [DW-1:0] model [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_master #(.AddrSize(AW), .WordSize(DW), .LenSize(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_en(mem_en), .mem_we(mem_we), .mem_re(mem_re), .mem_do(mem_do)
  );

  // Single-port synchronous RAM, DO registered on a read-enabled edge.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_di;
    if (mem_en && mem_re) mem_do <= ram[mem_addr];
  end

  always @(negedge clk) begin
    checks++;
    if (mem_we && mem_re) begin
      failures++;
      $display("FAIL we_re_exclusive: mem_we=%0b mem_re=%0b required not both 1", mem_we, mem_re);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one request and return at the falling edge of the cycle after acceptance.
  task automatic issue_req(input logic wr, input logic [AW-1:0] a,
                           input logic [LW-1:0] l, input logic [DW-1:0] d);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_timeout: req_ready=%0b required 1", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_wdata = d;
    if (wr) model[a] = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_data !== '0 ||
        busy !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
        mem_addr !== '0 || mem_di !== '0) begin
      failures++;
      $display("FAIL reset_values: rdy=%0b rv=%0b rl=%0b rd=%0h busy=%0b en=%0b we=%0b re=%0b addr=%0h di=%0h required all 0",
               req_ready, rsp_valid, rsp_last, rsp_data, busy, mem_en, mem_we, mem_re, mem_addr, mem_di);
    end
    rst = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: req_ready=%0b busy=%0b required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_write_read_single();
    issue_req(1'b1, 11'd5, 4'd0, 9'h1A5);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 11'd5 ||
        mem_di !== 9'h1A5 || req_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL write_cycle: en=%0b we=%0b re=%0b addr=%0d di=%0h rdy=%0b busy=%0b required 1/1/0/5/1a5/0/1",
               mem_en, mem_we, mem_re, mem_addr, mem_di, req_ready, busy);
    end
    step();
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || mem_di !== 9'h1A5) begin
      failures++;
      $display("FAIL write_done: en=%0b we=%0b rdy=%0b busy=%0b di=%0h required 0/0/1/0/1a5",
               mem_en, mem_we, req_ready, busy, mem_di);
    end
    issue_req(1'b0, 11'd5, 4'd0, 9'h000);
    checks++;
    if (mem_en !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'd5) begin
      failures++;
      $display("FAIL single_read_issue: en=%0b re=%0b we=%0b addr=%0d required 1/1/0/5",
               mem_en, mem_re, mem_we, mem_addr);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL single_read_wait: rsp_valid=%0b mem_en=%0b required 0/0", rsp_valid, mem_en);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 9'h1A5 || rsp_last !== 1'b1) begin
      failures++;
      $display("FAIL single_read_rsp: valid=%0b data=%0h last=%0b required 1/1a5/1",
               rsp_valid, rsp_data, rsp_last);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_read_end: valid=%0b rdy=%0b busy=%0b required 0/1/0", rsp_valid, req_ready, busy);
    end
  endtask

  // Four-word burst; optional consumer stall on one word and optional
  // flood of write requests while busy (must be ignored).
  task automatic run_burst(input logic [AW-1:0] a, input int stall_word,
                           input int stall_n, input bit flood);
    logic [AW-1:0] ea;
    issue_req(1'b0, a, 4'd3, 9'h000);
    if (flood) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = 9'h1FF;
    end
    for (int w = 0; w < 4; w++) begin
      ea = a + AW'(w);
      checks++;
      if (mem_en !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea ||
          req_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL burst_issue w%0d: en=%0b re=%0b we=%0b addr=%0d rdy=%0b busy=%0b required 1/1/0/%0d/0/1",
                 w, mem_en, mem_re, mem_we, mem_addr, req_ready, busy, ea);
      end
      step();
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL burst_wait w%0d: en=%0b we=%0b rsp_valid=%0b required 0/0/0", w, mem_en, mem_we, rsp_valid);
      end
      step();
      if (w == stall_word) begin
        for (int s = 0; s < stall_n; s++) begin
          rsp_ready = 1'b0;
          checks++;
          if (rsp_valid !== 1'b1 || rsp_data !== model[ea] || rsp_last !== (w == 3) ||
              mem_en !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL burst_stall w%0d s%0d: valid=%0b data=%0h last=%0b en=%0b required 1/%0h/%0b/0",
                     w, s, rsp_valid, rsp_data, rsp_last, mem_en, model[ea], (w == 3));
          end
          step();
        end
      end
      rsp_ready = 1'b1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== model[ea] || rsp_last !== (w == 3) ||
          mem_en !== 1'b0 || mem_we !== 1'b0) begin
        failures++;
        $display("FAIL burst_rsp w%0d: valid=%0b data=%0h last=%0b en=%0b required 1/%0h/%0b/0",
                 w, rsp_valid, rsp_data, rsp_last, mem_en, model[ea], (w == 3));
      end
      step();
    end
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL burst_end: rdy=%0b busy=%0b valid=%0b en=%0b required 1/0/0/0",
               req_ready, busy, rsp_valid, mem_en);
    end
  endtask

  task automatic test_burst();
    issue_req(1'b1, 11'd10, 4'd0, 9'd1);
    issue_req(1'b1, 11'd11, 4'd0, 9'd2);
    issue_req(1'b1, 11'd12, 4'd0, 9'd3);
    issue_req(1'b1, 11'd13, 4'd0, 9'd4);
    step();
    run_burst(11'd10, -1, 0, 1'b1);
    checks++;
    if (ram[10] !== 9'd1) begin
      failures++;
      $display("FAIL ignored_request: ram[10]=%0h required 1", ram[10]);
    end
  endtask

  task automatic test_wrap();
    ram[2046] = 9'h0AA; model[2046] = 9'h0AA;
    ram[2047] = 9'h155; model[2047] = 9'h155;
    ram[0]    = 9'h033; model[0]    = 9'h033;
    ram[1]    = 9'h1CC; model[1]    = 9'h1CC;
    run_burst(11'd2046, -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_burst(11'd10, 1, 5, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    issue_req(1'b0, 11'd10, 4'd3, 9'h000);
    step();                       // word 0 wait
    step();                       // word 0 hold, accepted
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 9'd1) begin
      failures++;
      $display("FAIL rstmid_word0: valid=%0b data=%0h required 1/1", rsp_valid, rsp_data);
    end
    step();                       // word 1 issue
    step();                       // word 1 wait
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0 || busy !== 1'b0 ||
        mem_en !== 1'b0 || mem_addr !== '0 || mem_di !== '0) begin
      failures++;
      $display("FAIL rstmid_values: rdy=%0b valid=%0b data=%0h busy=%0b en=%0b addr=%0h di=%0h required all 0",
               req_ready, rsp_valid, rsp_data, busy, mem_en, mem_addr, mem_di);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_quiet c%0d: valid=%0b en=%0b busy=%0b rdy=%0b required 0/0/0/1",
                 i, rsp_valid, mem_en, busy, req_ready);
      end
    end
    issue_req(1'b0, 11'd13, 4'd0, 9'h000);
    step();
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 9'd4 || rsp_last !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_after: valid=%0b data=%0h last=%0b required 1/4/1", rsp_valid, rsp_data, rsp_last);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = '0;
      model[i] = '0;
    end
    mem_do = '0;
    @(negedge clk);
    test_reset();
    test_write_read_single();
    test_burst();
    test_wrap();
    test_stall();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
